serial_word_assembler: RTL and testbench
========================================

# serial_word_assembler

Upstream feeder for the team's `n_bit_register`. It receives a framed serial bit stream qualified by a per-bit strobe and assembles each frame into an N-bit parallel word. On every valid frame it presents the word with a one-cycle load pulse, which drive the register's `d` and `enable` directly. It also reports parity and framing errors.

## Interface
Parameters:
- `N`, 8: data bits per frame and output word width; N >= 2.
- `PARITY_EN`, 1: 1 = an even-parity bit follows the data bits; 0 = no parity bit.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sin`  in  1  serial data bit; idle line level is 1.
- `sin_valid`  in  1  `sin` is sampled only on edges where this is 1; may be high every cycle.
- `word`  out  N  last correctly framed data word; feeds the register's `d`.
- `load`  out  1  one-cycle pulse when `word` updates; feeds the register's `enable`.
- `parity_err`  out  1  parity status of the word currently on `word`.
- `frame_err`  out  1  one-cycle pulse on a bad stop bit.
- `busy`  out  1  high while a frame is in progress (state != IDLE).

Clock and reset: one clock; reset is synchronous and active-high (`clk`, `reset`).

## Operation
Frame format, in bit order: start (0), N data bits LSB first, parity bit (only if PARITY_EN), stop (1).

FSM states are IDLE, DATA, PARITY, STOP. Every transition needs `sin_valid`=1; with `sin_valid`=0 the state, counter and shift register all hold.
- IDLE:
  - `sin`=0 goes to DATA; the bit counter clears to 0.
  - `sin`=1 is ignored (idle line).
- DATA:
  - Each sampled bit is written to shift-register position `cnt`, then `cnt` increments.
  - After bit N-1 is sampled, go to PARITY if PARITY_EN=1, else to STOP.
- PARITY:
  - Capture the parity bit.
  - Parity error flag = XOR of the N data bits XOR the parity bit (even parity: total number of ones must be even).
  - Go to STOP.
- STOP, with `sin`=1:
  - `word` takes the shift-register value.
  - `load`=1.
  - `parity_err` takes the parity error flag (0 when PARITY_EN=0).
  - Go to IDLE.
- STOP, with `sin`=0:
  - `frame_err`=1.
  - No load; `word` and `parity_err` are unchanged.
  - Go to IDLE.

Width rules:
- Bit counter width is $clog2(N+1).
- No wrap inside a frame; the counter clears on every start bit.

Output rules:
- Errored data is still delivered. A parity error does not suppress `load`; the consumer decides.
- `parity_err` is not sticky across frames. It is rewritten on every `load` and otherwise held.

Reset:
- Outputs: `word`=0, `load`=0, `parity_err`=0, `frame_err`=0, `busy`=0.
- Internal: state=IDLE, counter=0, shift register=0.
- Reset mid-frame aborts the frame with no `load` and no error pulse.
- Reset has priority over `sin_valid` on the same edge.

## Timing
- All outputs are registered. `busy` is decoded from the registered state.
- `word`, `load` and `parity_err` change on the edge that samples a valid stop bit. `load` is high for exactly that one cycle.
- `frame_err` is high for exactly one cycle, following the edge that samples a bad stop bit.
- With `sin_valid` continuously 1:
  - A frame occupies N+3 cycles (N+2 when PARITY_EN=0).
  - `busy` rises the cycle after the start bit is sampled.
  - `busy` falls in the same cycle that `load` or `frame_err` is high.
- Back-to-back frames are supported: a start bit sampled in the first cycle after the stop bit begins the next frame, with no gap required.
- `word` is stable between loads, so a downstream register sampling on `load` always captures a settled value.

## Test plan
All scenarios use N=8, PARITY_EN=1, `sin_valid`=1 every cycle unless stated.
- Single frame 0xA5: bits 0,1,0,1,0,0,1,0,1, parity 0, stop 1 -> `word`=0xA5, `load` pulses once, `parity_err`=0, `busy` high for 10 cycles.
- Parity error: frame 0x3C with parity bit 1 -> `word`=0x3C, `load` pulses, `parity_err`=1; a following clean 0x0F frame returns `parity_err` to 0.
- Framing error: frame 0x55 with stop bit 0, sent after a good 0xA5 -> `frame_err` pulses once, no `load`, `word` stays 0xA5.
- Gapped strobe: frame 0xC3 with `sin_valid` low for 3 cycles between each bit and garbage on `sin` during the gaps -> `word`=0xC3, a single `load`, gaps ignored.
- Reset mid-frame: assert `reset` for 1 cycle after 4 data bits, then send a full 0x81 frame -> no `load` for the aborted frame, then `word`=0x81, one `load`.
- Back-to-back: frames 0x01 (parity 1) and 0xFE (parity 1) with no idle between them, plus idle-high bits beforehand -> two `load` pulses 11 cycles apart, `word`=0x01 then 0xFE, no errors, idle bits ignored.

Source files
------------

// File: rtl/serial_word_assembler_if.sv
// Bus between a framed serial source and the word assembler.
// The master drives the serial line and strobe; the slave returns the assembled word and status.
interface serial_word_assembler_if #(
  parameter int unsigned N = 8
);

  logic         sin;
  logic         sin_valid;
  logic [N-1:0] word;
  logic         load;
  logic         parity_err;
  logic         frame_err;
  logic         busy;

  modport master (
    output sin,
    output sin_valid,
    input  word,
    input  load,
    input  parity_err,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  sin,
    input  sin_valid,
    output word,
    output load,
    output parity_err,
    output frame_err,
    output busy
  );

endinterface

// File: rtl/serial_word_assembler.sv
// Assembles start/data/parity/stop serial frames into N-bit words with a one-cycle load pulse.
// Parity and framing problems are reported; errored-parity data is still delivered.
module serial_word_assembler #(
  parameter int unsigned N         = 8,
  parameter bit          PARITY_EN = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  serial_word_assembler_if.slave    bus
);

  localparam int unsigned CW = $clog2(N + 1);

  if (N < 2) begin : g_bad_n
    $error("serial_word_assembler: N must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  shreg;
  logic          perr;
  logic [N-1:0]  word_q;
  logic          load_q;
  logic          perr_q;
  logic          ferr_q;

  // Frame sequencer; every move is qualified by sin_valid, pulses self-clear each cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      shreg  <= '0;
      perr   <= 1'b0;
      word_q <= '0;
      load_q <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      load_q <= 1'b0;
      ferr_q <= 1'b0;
      if (bus.sin_valid) begin
        case (state)
          IDLE: begin
            if (!bus.sin) begin
              state <= DATA;
              cnt   <= '0;
            end
          end
          DATA: begin
            for (int unsigned i = 0; i < N; i++) begin
              if (cnt == CW'(i)) shreg[i] <= bus.sin;
            end
            cnt <= cnt + CW'(1);
            if (cnt == CW'(N - 1)) state <= PARITY_EN ? PARITY : STOP;
          end
          PARITY: begin
            // Even parity: a set flag means the total count of ones was odd.
            perr  <= (^shreg) ^ bus.sin;
            state <= STOP;
          end
          STOP: begin
            if (bus.sin) begin
              word_q <= shreg;
              load_q <= 1'b1;
              perr_q <= PARITY_EN ? perr : 1'b0;
            end else begin
              ferr_q <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.word       = word_q;
  assign bus.load       = load_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_serial_word_assembler.sv
// Bench for serial_word_assembler: frame-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized frames.
module tb_serial_word_assembler;

  localparam int unsigned N = 8;
  localparam int R_NONE  = 0;
  localparam int R_START = 1;
  localparam int R_STOP  = 2;

  logic clk;
  logic reset;

  serial_word_assembler_if #(.N(N)) bus_if ();

  serial_word_assembler #(.N(N), .PARITY_EN(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] exp_word;
  logic         exp_load, exp_perr, exp_ferr, exp_busy;
  logic [N-1:0] cur_data;
  logic         cur_par;

  int chk_cnt, pass_cnt;
  int cyc, load_cnt, ferr_cnt, busy_cyc, last_load_cyc, prev_load_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
  endtask

  // One clock: drive inputs, let the frame-level model react to what was sampled, compare at negedge.
  task automatic tick(input logic s, input logic v, input logic r, input int role);
    bus_if.sin       = s;
    bus_if.sin_valid = v;
    reset            = r;
    @(posedge clk);
    cyc++;
    exp_load = 1'b0;
    exp_ferr = 1'b0;
    if (r) begin
      exp_word = '0;
      exp_perr = 1'b0;
      exp_busy = 1'b0;
    end else if (v) begin
      if (role == R_START) exp_busy = 1'b1;
      else if (role == R_STOP) begin
        exp_busy = 1'b0;
        if (s) begin
          exp_word = cur_data;
          exp_load = 1'b1;
          exp_perr = ^{cur_data, cur_par};
        end else begin
          exp_ferr = 1'b1;
        end
      end
    end
    @(negedge clk);
    check("word",       32'(bus_if.word),       32'(exp_word));
    check("load",       32'(bus_if.load),       32'(exp_load));
    check("parity_err", 32'(bus_if.parity_err), 32'(exp_perr));
    check("frame_err",  32'(bus_if.frame_err),  32'(exp_ferr));
    check("busy",       32'(bus_if.busy),       32'(exp_busy));
    if (bus_if.load === 1'b1) begin
      load_cnt++;
      prev_load_cyc = last_load_cyc;
      last_load_cyc = cyc;
    end
    if (bus_if.frame_err === 1'b1) ferr_cnt++;
    if (bus_if.busy === 1'b1) busy_cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b1, 1'b0, R_NONE);
  endtask

  task automatic gaps(input int gmin, input int gmax);
    int n;
    n = int'($urandom_range(gmax, gmin));
    for (int g = 0; g < n; g++) tick(1'($urandom), 1'b0, 1'b0, R_NONE);
  endtask

  // Full frame: start, N data bits LSB first, parity bit, stop bit.
  task automatic send_frame(input logic [N-1:0] data, input logic par, input logic stop,
                            input int gmin, input int gmax);
    cur_data = data;
    cur_par  = par;
    for (int i = 0; i < int'(N) + 3; i++) begin
      gaps(gmin, gmax);
      if (i == 0)                tick(1'b0, 1'b1, 1'b0, R_START);
      else if (i <= int'(N))     tick(data[i-1], 1'b1, 1'b0, R_NONE);
      else if (i == int'(N) + 1) tick(par, 1'b1, 1'b0, R_NONE);
      else                       tick(stop, 1'b1, 1'b0, R_STOP);
    end
  endtask

  task automatic send_partial(input logic [N-1:0] data, input int nbits);
    cur_data = data;
    tick(1'b0, 1'b1, 1'b0, R_START);
    for (int i = 0; i < nbits; i++) tick(data[i], 1'b1, 1'b0, R_NONE);
  endtask

  initial begin
    int base_load, base_ferr, base_busy;
    logic [N-1:0] d;
    logic p;
    chk_cnt = 0; pass_cnt = 0; cyc = 0;
    load_cnt = 0; ferr_cnt = 0; busy_cyc = 0; last_load_cyc = 0; prev_load_cyc = 0;
    exp_word = '0; exp_load = 1'b0; exp_perr = 1'b0; exp_ferr = 1'b0; exp_busy = 1'b0;
    cur_data = '0; cur_par = 1'b0;

    tick(1'b1, 1'b0, 1'b1, R_NONE);
    tick(1'b0, 1'b1, 1'b1, R_NONE);
    check("reset_word", 32'(bus_if.word), 32'h0);
    idle(2);

    // Single 0xA5 frame
    base_load = load_cnt; base_busy = busy_cyc;
    send_frame(8'hA5, 1'b0, 1'b1, 0, 0);
    idle(2);
    check("a5_word",       32'(bus_if.word), 32'hA5);
    check("a5_loads",      32'(load_cnt - base_load), 32'd1);
    check("a5_busy_cycles", 32'(busy_cyc - base_busy), 32'd10);

    // Parity error, then a clean frame clears the flag
    send_frame(8'h3C, 1'b1, 1'b1, 0, 0);
    check("3c_word", 32'(bus_if.word), 32'h3C);
    check("3c_perr", 32'(bus_if.parity_err), 32'd1);
    send_frame(8'h0F, 1'b0, 1'b1, 0, 0);
    check("0f_perr", 32'(bus_if.parity_err), 32'd0);
    idle(1);

    // Framing error after a good frame
    send_frame(8'hA5, 1'b0, 1'b1, 0, 0);
    base_load = load_cnt; base_ferr = ferr_cnt;
    send_frame(8'h55, 1'b0, 1'b0, 0, 0);
    idle(2);
    check("55_ferr_pulses", 32'(ferr_cnt - base_ferr), 32'd1);
    check("55_no_load",     32'(load_cnt - base_load), 32'd0);
    check("55_word_held",   32'(bus_if.word), 32'hA5);

    // Gapped strobe with garbage between bits
    base_load = load_cnt;
    send_frame(8'hC3, 1'b0, 1'b1, 3, 3);
    idle(2);
    check("c3_word",  32'(bus_if.word), 32'hC3);
    check("c3_loads", 32'(load_cnt - base_load), 32'd1);

    // Reset mid-frame, with sin_valid high on the reset edge
    base_load = load_cnt; base_ferr = ferr_cnt;
    send_partial(8'h5A, 4);
    tick(1'b0, 1'b1, 1'b1, R_NONE);
    check("rst_word", 32'(bus_if.word), 32'h0);
    send_frame(8'h81, 1'b0, 1'b1, 0, 0);
    idle(2);
    check("81_word",  32'(bus_if.word), 32'h81);
    check("81_loads", 32'(load_cnt - base_load), 32'd1);
    check("81_ferr",  32'(ferr_cnt - base_ferr), 32'd0);

    // Back-to-back frames after idle-high bits
    idle(3);
    base_load = load_cnt; base_ferr = ferr_cnt;
    send_frame(8'h01, 1'b1, 1'b1, 0, 0);
    check("b2b_first", 32'(bus_if.word), 32'h01);
    send_frame(8'hFE, 1'b1, 1'b1, 0, 0);
    idle(2);
    check("b2b_loads",   32'(load_cnt - base_load), 32'd2);
    check("b2b_spacing", 32'(last_load_cyc - prev_load_cyc), 32'd11);
    check("b2b_word",    32'(bus_if.word), 32'hFE);
    check("b2b_perr",    32'(bus_if.parity_err), 32'd0);
    check("b2b_ferr",    32'(ferr_cnt - base_ferr), 32'd0);

    // Randomized frames, gaps, idle bits, bad parity/stop and occasional aborts
    for (int k = 0; k < 60; k++) begin
      d = N'($urandom);
      p = (^d) ^ ($urandom_range(4, 0) == 0);
      if ($urandom_range(9, 0) == 0) begin
        send_partial(d, int'($urandom_range(N - 1, 0)));
        tick(1'($urandom), 1'($urandom), 1'b1, R_NONE);
      end else begin
        send_frame(d, p, ($urandom_range(5, 0) != 0), 0, ($urandom_range(2, 0) == 0) ? 2 : 0);
      end
      idle(int'($urandom_range(2, 0)));
    end
    idle(2);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got cycle %0d required finish", cyc);
    $fatal(1);
  end

endmodule
